// File: rtl/switch_box_cfg.sv
// Disjoint FPGA routing switch box with a serial daisy-chained config shadow
// register, commit into the active select register, and an optional output register.
module switch_box_cfg #(
  parameter int unsigned W       = 4,
  parameter int unsigned REG_OUT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_in,
  input  logic         cfg_valid,
  input  logic         cfg_commit,
  output logic         cfg_out,
  output logic         cfg_full,
  output logic         cfg_err,
  output logic         cfg_active,
  input  logic [W-1:0] left_in,
  input  logic [W-1:0] top_in,
  input  logic [W-1:0] right_in,
  input  logic [W-1:0] bottom_in,
  output logic [W-1:0] left_out,
  output logic [W-1:0] top_out,
  output logic [W-1:0] right_out,
  output logic [W-1:0] bottom_out
);

  localparam int unsigned CFG_W = 8 * W;
  localparam int unsigned CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             act_q, act_d;
  logic             commit_ok;

  assign commit_ok = cfg_commit && (state_q == ST_FULL);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next-state logic; a commit coinciding with a shift restarts loading
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:   if (cfg_valid) state_d = ST_LOADING;
      ST_LOADING: if (cfg_valid && (cnt_q == CNT_LAST)) state_d = ST_FULL;
      ST_FULL:    if (cfg_commit) state_d = cfg_valid ? ST_LOADING : ST_EMPTY;
      default:    state_d = ST_EMPTY;
    endcase
  end

  // Shadow shift, bit count, commit and error pulse
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    err_d    = 1'b0;
    act_d    = act_q;
    if (cfg_valid) begin
      shadow_d = {shadow_q[CFG_W-2:0], cfg_in};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end
    if (commit_ok) begin
      active_d = shadow_q;
      act_d    = 1'b1;
      cnt_d    = cfg_valid ? CNT_W'(1) : '0;
    end else if (cfg_commit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '1;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      act_q    <= act_d;
    end
  end

  assign cfg_out    = shadow_q[CFG_W-1];
  assign cfg_full   = (state_q == ST_FULL);
  assign cfg_err    = err_q;
  assign cfg_active = act_q;

  logic [W-1:0] side_in    [4];
  logic [W-1:0] side_out_c [4];
  logic [1:0]   sel;
  logic [1:0]   src;

  assign side_in[0] = left_in;
  assign side_in[1] = top_in;
  assign side_in[2] = right_in;
  assign side_in[3] = bottom_in;

  // Sides are numbered clockwise, so the source is always (side + sel + 1) mod 4
  always_comb begin
    sel = '0;
    src = '0;
    for (int s = 0; s < 4; s++) begin
      side_out_c[s] = '0;
      for (int j = 0; j < int'(W); j++) begin
        sel = active_q[2*(s*int'(W)+j) +: 2];
        src = 2'(s) + sel + 2'd1;
        if (sel != 2'd3) side_out_c[s][j] = side_in[src][j];
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [W-1:0] out_q [4];

    always_ff @(posedge clk) begin
      for (int s = 0; s < 4; s++) begin
        if (reset) out_q[s] <= '0;
        else       out_q[s] <= side_out_c[s];
      end
    end

    assign left_out   = out_q[0];
    assign top_out    = out_q[1];
    assign right_out  = out_q[2];
    assign bottom_out = out_q[3];
  end else begin : g_comb_out
    assign left_out   = side_out_c[0];
    assign top_out    = side_out_c[1];
    assign right_out  = side_out_c[2];
    assign bottom_out = side_out_c[3];
  end

endmodule

// File: tb/tb_switch_box_cfg.sv
// Bench for switch_box_cfg: W=4 combinational and registered instances share
// stimulus; W=1 and W=8 instances take random configs against a field-level model.
module tb_switch_box_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cin  [3];
  logic       cval [3];
  logic       ccom [3];
  logic [3:0] in4 [4];
  logic [0:0] in1 [4];
  logic [7:0] in8 [4];
  logic [3:0] oa [4];
  logic [3:0] ob [4];
  logic [0:0] o1 [4];
  logic [7:0] o8 [4];
  logic [3:0] co, full, err, act;

  int checks = 0;
  int errors = 0;

  // Source side for each output side, indexed by select value 0..2
  int src_tab [4][3] = '{'{1, 2, 3}, '{2, 3, 0}, '{3, 0, 1}, '{0, 1, 2}};

  int         sel4 [4][8];
  int         xsel [4][8];
  int         rsel [4][8];
  logic [7:0] ins  [4];
  logic [7:0] r8;
  logic [31:0] old_exp;
  bit         bq [$];
  bit         b;

  switch_box_cfg #(.W(4), .REG_OUT(0)) u_a (
    .clk(clk), .reset(reset), .cfg_in(cin[0]), .cfg_valid(cval[0]), .cfg_commit(ccom[0]),
    .cfg_out(co[0]), .cfg_full(full[0]), .cfg_err(err[0]), .cfg_active(act[0]),
    .left_in(in4[0]), .top_in(in4[1]), .right_in(in4[2]), .bottom_in(in4[3]),
    .left_out(oa[0]), .top_out(oa[1]), .right_out(oa[2]), .bottom_out(oa[3]));

  switch_box_cfg #(.W(4), .REG_OUT(1)) u_b (
    .clk(clk), .reset(reset), .cfg_in(cin[0]), .cfg_valid(cval[0]), .cfg_commit(ccom[0]),
    .cfg_out(co[1]), .cfg_full(full[1]), .cfg_err(err[1]), .cfg_active(act[1]),
    .left_in(in4[0]), .top_in(in4[1]), .right_in(in4[2]), .bottom_in(in4[3]),
    .left_out(ob[0]), .top_out(ob[1]), .right_out(ob[2]), .bottom_out(ob[3]));

  switch_box_cfg #(.W(1), .REG_OUT(0)) u_w1 (
    .clk(clk), .reset(reset), .cfg_in(cin[1]), .cfg_valid(cval[1]), .cfg_commit(ccom[1]),
    .cfg_out(co[2]), .cfg_full(full[2]), .cfg_err(err[2]), .cfg_active(act[2]),
    .left_in(in1[0]), .top_in(in1[1]), .right_in(in1[2]), .bottom_in(in1[3]),
    .left_out(o1[0]), .top_out(o1[1]), .right_out(o1[2]), .bottom_out(o1[3]));

  switch_box_cfg #(.W(8), .REG_OUT(0)) u_w8 (
    .clk(clk), .reset(reset), .cfg_in(cin[2]), .cfg_valid(cval[2]), .cfg_commit(ccom[2]),
    .cfg_out(co[3]), .cfg_full(full[3]), .cfg_err(err[3]), .cfg_active(act[3]),
    .left_in(in8[0]), .top_in(in8[1]), .right_in(in8[2]), .bottom_in(in8[3]),
    .left_out(o8[0]), .top_out(o8[1]), .right_out(o8[2]), .bottom_out(o8[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic send(input int g, input logic bit_v);
    cin[g]  = bit_v;
    cval[g] = 1'b1;
    tick();
    cval[g] = 1'b0;
  endtask

  task automatic commit(input int g);
    ccom[g] = 1'b1;
    tick();
    ccom[g] = 1'b0;
  endtask

  // Serialise select fields MSB first: highest track index of bottom goes out first
  function automatic void ser(input int nw, input int sel [4][8]);
    logic [1:0] f;
    for (int k = 4*nw - 1; k >= 0; k--) begin
      f = 2'(sel[k / nw][k % nw]);
      bq.push_back(f[1]);
      bq.push_back(f[0]);
    end
  endfunction

  task automatic send_q(input int g);
    while (bq.size() > 0) send(g, bq.pop_front());
  endtask

  function automatic logic [31:0] model(input int nw, input int sel [4][8], input logic [7:0] iv [4]);
    logic [31:0] r;
    r = '0;
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < nw; j++)
        if (sel[s][j] != 3) r[(3-s)*nw + j] = iv[src_tab[s][sel[s][j]]][j];
    return r;
  endfunction

  function automatic logic [31:0] obs(input int i);
    case (i)
      0:       return 32'({oa[0], oa[1], oa[2], oa[3]});
      1:       return 32'({ob[0], ob[1], ob[2], ob[3]});
      2:       return 32'({o1[0], o1[1], o1[2], o1[3]});
      default: return {o8[0], o8[1], o8[2], o8[3]};
    endcase
  endfunction

  task automatic set_in(input int g, input logic [7:0] iv [4]);
    for (int s = 0; s < 4; s++) begin
      if (g == 0)      in4[s] = iv[s][3:0];
      else if (g == 1) in1[s] = iv[s][0:0];
      else             in8[s] = iv[s];
    end
  endtask

  task automatic fill_sel(output int sel [4][8], input int v);
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 8; j++) sel[s][j] = v;
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      cin[g] = 1'b0; cval[g] = 1'b0; ccom[g] = 1'b0;
    end
    for (int s = 0; s < 4; s++) ins[s] = 8'hFF;
    for (int g = 0; g < 3; g++) set_in(g, ins);
    repeat (2) tick();

    // Reset with all inputs high: everything off
    for (int i = 0; i < 4; i++) chk($sformatf("rst_out%0d", i), obs(i), 0);
    chk("rst_status", {full, act, err, co}, 0);
    reset = 1'b0;
    tick();
    chk("rst_out_after", obs(0) | obs(1) | obs(2) | obs(3), 0);
    chk("rst_active", act, 0);

    // Every field = opposite side
    fill_sel(sel4, 1);
    bq.delete();
    ser(4, sel4);
    send_q(0);
    chk("full_32", full[1:0], 2'b11);
    for (int s = 0; s < 4; s++) ins[s] = 8'h00;
    ins[2] = 8'h0A;
    set_in(0, ins);
    commit(0);
    chk("opp_cfg_out", obs(0), 32'h0000A000);
    chk("full_cleared", full[1:0], 2'b00);
    chk("active_set", act[1:0], 2'b11);
    chk("reg_lag_cfg", obs(1), 0);
    tick();
    chk("reg_cfg_out", obs(1), 32'h0000A000);

    // Early commit errors and keeps progress
    repeat (20) send(0, 1'b0);
    commit(0);
    chk("err_pulse", err[1:0], 2'b11);
    chk("err_out_kept", obs(0), 32'h0000A000);
    tick();
    chk("err_one_cycle", err[1:0], 2'b00);
    repeat (11) send(0, 1'b0);
    chk("full_31", full[1:0], 2'b00);
    send(0, 1'b0);
    chk("full_after_err", full[1:0], 2'b11);
    commit(0);
    fill_sel(sel4, 0);
    chk("cw_cfg_out", obs(0), 32'h00000A00);
    tick();

    // Chain pass-through: first 8 bits reappear on cfg_out
    r8 = 8'($urandom);
    fill_sel(xsel, 2);
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(r8[7-i]);
    ser(4, xsel);
    for (int n = 0; n < 40; n++) begin
      b = bq.pop_front();
      if (n >= 32) chk($sformatf("chain_bit%0d", n - 32), co[1:0], {2{r8[7-(n-32)]}});
      send(0, b);
    end
    chk("full_40", full[1:0], 2'b11);

    // Commit with simultaneous shift in FULL
    for (int s = 0; s < 4; s++) ins[s] = 8'($urandom);
    set_in(0, ins);
    cin[0] = 1'b1; cval[0] = 1'b1; ccom[0] = 1'b1;
    tick();
    cval[0] = 1'b0; ccom[0] = 1'b0;
    sel4 = xsel;
    chk("commit_shift_out", obs(0), model(4, sel4, ins));
    chk("commit_shift_full", full[1:0], 2'b00);
    repeat (30) send(0, 1'b0);
    chk("count1_not_full", full[1:0], 2'b00);
    send(0, 1'b0);
    chk("count1_full", full[1:0], 2'b11);

    // Registered output lags data by one cycle
    old_exp = model(4, sel4, ins);
    chk("reg_settled", obs(1), old_exp);
    for (int s = 0; s < 4; s++) ins[s] = ~ins[s];
    set_in(0, ins);
    #1;
    chk("comb_toggle", obs(0), model(4, sel4, ins));
    chk("reg_toggle_lag", obs(1), old_exp);
    tick();
    chk("reg_toggle", obs(1), model(4, sel4, ins));

    // Reset mid-load
    repeat (10) send(0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 0; s < 4; s++) ins[s] = 8'hFF;
    set_in(0, ins);
    #1;
    chk("midrst_out", obs(0) | obs(1), 0);
    chk("midrst_status", {full[1:0], act[1:0]}, 0);
    repeat (31) send(0, 1'b1);
    chk("midrst_cnt31", full[1:0], 2'b00);
    send(0, 1'b1);
    chk("midrst_cnt32", full[1:0], 2'b11);
    chk("midrst_out_idle", obs(0) | obs(1), 0);

    // Random configs and inputs for W=1 and W=8
    for (int g = 1; g < 3; g++) begin
      int nw;
      nw = (g == 1) ? 1 : 8;
      for (int c = 0; c < 50; c++) begin
        for (int s = 0; s < 4; s++)
          for (int j = 0; j < 8; j++) rsel[s][j] = int'($urandom_range(0, 3));
        bq.delete();
        ser(nw, rsel);
        send_q(g);
        if (c == 0) chk($sformatf("rand_full_w%0d", nw), full[g+1], 1'b1);
        commit(g);
        if (c == 0) chk($sformatf("rand_active_w%0d", nw), act[g+1], 1'b1);
        for (int v = 0; v < 10; v++) begin
          for (int s = 0; s < 4; s++) ins[s] = 8'($urandom);
          set_in(g, ins);
          #2;
          chk($sformatf("rand_w%0d_c%0d_v%0d", nw, c, v), obs(g + 1), model(nw, rsel, ins));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
